// File: rtl/register_mux.sv
// register_mux: falling-edge registered selector for an FFT butterfly.
// Two data words are picked from a packed register file, and a twiddle
// pair W_N^k = cos - j*sin (Q1.7, 9-bit two's complement) is looked up.
// Every output is captured on the same falling edge when en is high.
// The twiddle ROM covers 64 points. Smaller power-of-two sizes (4..64)
// reuse it by scaling the index up to the 64-point grid.
module register_mux #(
    parameter int D_WIDTH = 64,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 6,
    parameter int TW_W    = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [D_WIDTH*DATA_W-1:0] regs,
    input  logic [IDX_W-1:0]          idx_a,
    input  logic [IDX_W-1:0]          idx_b,
    input  logic [IDX_W-1:0]          tw_sel_re,
    input  logic [IDX_W-1:0]          tw_sel_im,
    output logic [DATA_W-1:0]         reg_a,
    output logic [DATA_W-1:0]         reg_b,
    output logic [TW_W-1:0]           tw_re,
    output logic [TW_W-1:0]           tw_im,
    output logic                      valid
);

    // Index scaling onto the 64-point ROM grid.
    localparam int SH = 6 - IDX_W;

    logic [DATA_W-1:0]      w_sel_a;
    logic [DATA_W-1:0]      w_sel_b;
    logic [5:0]             w_k_re;
    logic [5:0]             w_k_im;
    logic [5:0]             w_k_im_sh;
    logic signed [TW_W-1:0] w_tw_re;
    logic signed [TW_W-1:0] w_tw_im;

    logic [DATA_W-1:0]      r_reg_a_p1;
    logic [DATA_W-1:0]      r_reg_b_p1;
    logic signed [TW_W-1:0] r_tw_re_p1;
    logic signed [TW_W-1:0] r_tw_im_p1;
    logic                   r_vld_p1;

    // First quadrant of round(128*cos(2*pi*m/64)), m = 0..16.
    // Values are rounded half away from zero; no entry falls exactly on .5.
    function automatic int quarter_cos(input int m);
        int v;
        v = 0;
        case (m)
            0:  v = 128;
            1:  v = 127;
            2:  v = 126;
            3:  v = 122;
            4:  v = 118;
            5:  v = 113;
            6:  v = 106;
            7:  v = 99;
            8:  v = 91;
            9:  v = 81;
            10: v = 71;
            11: v = 60;
            12: v = 49;
            13: v = 37;
            14: v = 25;
            15: v = 13;
            default: v = 0;
        endcase
        return v;
    endfunction

    // Full-period cosine, built from the first quadrant by symmetry.
    // Rounding is symmetric, so negating a quadrant is exact.
    function automatic int cos_lut(input logic [5:0] k);
        int ki;
        int v;
        ki = int'(k);
        if (ki <= 16) begin
            v = quarter_cos(ki);
        end else if (ki <= 32) begin
            v = -quarter_cos(32 - ki);
        end else if (ki <= 48) begin
            v = -quarter_cos(ki - 32);
        end else begin
            v = quarter_cos(64 - ki);
        end
        return v;
    endfunction

    assign w_sel_a   = regs[int'(idx_a)*DATA_W +: DATA_W];
    assign w_sel_b   = regs[int'(idx_b)*DATA_W +: DATA_W];
    assign w_k_re    = 6'(tw_sel_re) << SH;
    assign w_k_im    = 6'(tw_sel_im) << SH;
    // -sin(t) = cos(t + pi/2), so the imaginary entry is a quarter-period shift.
    // The 6-bit sum wraps modulo 64.
    assign w_k_im_sh = w_k_im + 6'd16;

    // Constant twiddle lookups for both independent selects.
    always_comb begin
        w_tw_re = TW_W'(cos_lut(w_k_re));
        w_tw_im = TW_W'(cos_lut(w_k_im_sh));
    end

    // ---- stage p1: falling-edge capture, asynchronous active-low clear ----
    // Load the data and twiddle registers on enabled edges; valid follows en.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_a_p1 <= '0;
            r_reg_b_p1 <= '0;
            r_tw_re_p1 <= '0;
            r_tw_im_p1 <= '0;
            r_vld_p1   <= 1'b0;
        end else begin
            r_vld_p1 <= en;
            if (en) begin
                r_reg_a_p1 <= w_sel_a;
                r_reg_b_p1 <= w_sel_b;
                r_tw_re_p1 <= w_tw_re;
                r_tw_im_p1 <= w_tw_im;
            end
        end
    end

    assign reg_a = r_reg_a_p1;
    assign reg_b = r_reg_b_p1;
    assign tw_re = r_tw_re_p1;
    assign tw_im = r_tw_im_p1;
    assign valid = r_vld_p1;

endmodule

// File: tb/tb_register_mux.sv
// tb_register_mux: directed and random stimulus for register_mux.
// Expected results come from a scoreboard queue.
// Twiddle reference values use real-valued trig with half-away rounding.
module tb_register_mux;

    localparam int D  = 64;
    localparam int W  = 16;
    localparam int IW = 6;
    localparam int TW = 9;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] re;
        logic [TW-1:0] im;
        logic          v;
    } exp_t;

    logic          clk = 1'b1;
    logic          rst;
    logic          en;
    logic [D*W-1:0] regs;
    logic [IW-1:0] idx_a, idx_b, tw_sel_re, tw_sel_im;
    logic [W-1:0]  reg_a, reg_b;
    logic [TW-1:0] tw_re, tw_im;
    logic          valid;

    // Shadow stimulus, applied to the ports at the next rising edge.
    logic [W-1:0]  s_mem [D];
    logic [IW-1:0] s_ia, s_ib, s_sr, s_si;

    // Reference model state.
    logic [W-1:0]  m_a, m_b;
    logic [TW-1:0] m_re, m_im;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    register_mux #(.D_WIDTH(D), .DATA_W(W), .IDX_W(IW), .TW_W(TW)) dut (
        .clk(clk), .rst(rst), .en(en), .regs(regs),
        .idx_a(idx_a), .idx_b(idx_b), .tw_sel_re(tw_sel_re), .tw_sel_im(tw_sel_im),
        .reg_a(reg_a), .reg_b(reg_b), .tw_re(tw_re), .tw_im(tw_im), .valid(valid)
    );

    always #5 clk = ~clk;

    function automatic int rnd_half_away(input real x);
        if (x >= 0.0) return int'($floor(x + 0.5));
        else          return -int'($floor(-x + 0.5));
    endfunction

    function automatic logic [TW-1:0] ref_re(input int k);
        return TW'(rnd_half_away(128.0 * $cos(2.0 * 3.14159265358979 * k / D)));
    endfunction

    function automatic logic [TW-1:0] ref_im(input int k);
        return TW'(rnd_half_away(-128.0 * $sin(2.0 * 3.14159265358979 * k / D)));
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_zero(input string tag);
        cmp({tag, ".reg_a"}, 64'(reg_a), 64'd0);
        cmp({tag, ".reg_b"}, 64'(reg_b), 64'd0);
        cmp({tag, ".tw_re"}, 64'(tw_re), 64'd0);
        cmp({tag, ".tw_im"}, 64'(tw_im), 64'd0);
        cmp({tag, ".valid"}, 64'(valid), 64'd0);
    endtask

    task automatic apply(input logic e);
        for (int i = 0; i < D; i++) regs[i*W +: W] = s_mem[i];
        idx_a = s_ia; idx_b = s_ib; tw_sel_re = s_sr; tw_sel_im = s_si;
        en = e;
    endtask

    // One clock: drive at the rising edge, predict, then check after the falling edge.
    task automatic step(input string tag, input logic e);
        exp_t x;
        @(posedge clk);
        apply(e);
        if (e) begin
            m_a  = s_mem[s_ia];
            m_b  = s_mem[s_ib];
            m_re = ref_re(int'(s_sr));
            m_im = ref_im(int'(s_si));
        end
        x.a = m_a; x.b = m_b; x.re = m_re; x.im = m_im; x.v = e;
        sbq.push_back(x);
        @(negedge clk);
        #1;
        x = sbq.pop_front();
        cmp({tag, ".reg_a"}, 64'(reg_a), 64'(x.a));
        cmp({tag, ".reg_b"}, 64'(reg_b), 64'(x.b));
        cmp({tag, ".tw_re"}, 64'(tw_re), 64'(x.re));
        cmp({tag, ".tw_im"}, 64'(tw_im), 64'(x.im));
        cmp({tag, ".valid"}, 64'(valid), 64'(x.v));
    endtask

    task automatic randomize_shadow();
        for (int i = 0; i < D; i++) s_mem[i] = W'($urandom);
        s_ia = IW'($urandom); s_ib = IW'($urandom);
        s_sr = IW'($urandom); s_si = IW'($urandom);
    endtask

    initial begin
        // Reset with arbitrary inputs, before any clock edge.
        rst = 1'b1;
        randomize_shadow();
        apply(1'b1);
        #2 rst = 1'b0;
        #1 cmp_zero("rst_async");
        @(negedge clk); #1;
        cmp_zero("rst_held");
        m_a = '0; m_b = '0; m_re = '0; m_im = '0;
        @(posedge clk);
        rst = 1'b1;
        en  = 1'b0;
        step("rel0", 1'b0);
        step("rel1", 1'b0);

        // Data select.
        for (int i = 0; i < D; i++) s_mem[i] = W'(16'h1000 + i);
        s_ia = 6'd5; s_ib = 6'd37; s_sr = 6'd0; s_si = 6'd0;
        step("dsel", 1'b1);
        cmp("dsel_a_const", 64'(reg_a), 64'h1005);
        cmp("dsel_b_const", 64'(reg_b), 64'h1025);
        cmp("dsel_v_const", 64'(valid), 64'd1);

        // Twiddle reference points.
        s_sr = 6'd0;  s_si = 6'd0;  step("tw0", 1'b1);
        cmp("tw0_re", 64'(tw_re), 64'h080); cmp("tw0_im", 64'(tw_im), 64'h000);
        s_sr = 6'd8;  s_si = 6'd8;  step("tw8", 1'b1);
        cmp("tw8_re", 64'(tw_re), 64'h05B); cmp("tw8_im", 64'(tw_im), 64'h1A5);
        s_sr = 6'd16; s_si = 6'd16; step("tw16", 1'b1);
        cmp("tw16_re", 64'(tw_re), 64'h000); cmp("tw16_im", 64'(tw_im), 64'h180);
        s_sr = 6'd32; s_si = 6'd32; step("tw32", 1'b1);
        cmp("tw32_re", 64'(tw_re), 64'h180); cmp("tw32_im", 64'(tw_im), 64'h000);
        s_sr = 6'd48; s_si = 6'd48; step("tw48", 1'b1);
        cmp("tw48_re", 64'(tw_re), 64'h000); cmp("tw48_im", 64'(tw_im), 64'h080);

        // Quarter-period relation, exhaustive over k.
        for (int k = 0; k < D; k++) begin
            s_sr = IW'((k + 16) % D);
            s_si = IW'(k);
            step($sformatf("qoff%0d", k), 1'b1);
            cmp($sformatf("qoff%0d_eq", k), 64'(tw_re), 64'(tw_im));
        end

        // Equal selects, then hold while everything changes.
        s_ia = 6'd63; s_ib = 6'd63; s_sr = 6'd3; s_si = 6'd59;
        step("eq_load", 1'b1);
        cmp("eq_a_b", 64'(reg_a), 64'(reg_b));
        cmp("eq_a_63", 64'(reg_a), 64'h103F);
        for (int n = 0; n < 3; n++) begin
            randomize_shadow();
            step($sformatf("hold%0d", n), 1'b0);
            cmp($sformatf("hold%0d_a", n), 64'(reg_a), 64'h103F);
        end

        // Random streaming with random enable.
        for (int n = 0; n < 20; n++) begin
            randomize_shadow();
            step($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)));
        end

        // Async reset mid-stream.
        randomize_shadow(); step("ms0", 1'b1);
        randomize_shadow(); step("ms1", 1'b1);
        randomize_shadow();
        @(posedge clk);
        apply(1'b1);
        #2 rst = 1'b0;
        #1 cmp_zero("ms_rst_now");
        @(negedge clk); #1;
        cmp_zero("ms_rst_edge");
        @(posedge clk);
        rst = 1'b1;
        m_a = '0; m_b = '0; m_re = '0; m_im = '0;
        randomize_shadow();
        step("ms_fresh", 1'b1);
        randomize_shadow();
        step("ms_fresh2", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
